// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - opcodes, instruction format enum and decoded field struct
package decode_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  // XLEN-independent part of a decoded instruction; pc/imm are added by the stage
  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    fmt_e       fmt;
    logic       illegal;
  } decoded_t;

endpackage

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - format classification, immediate extraction and illegal-encoding check
module imm_gen
  import decode_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit SUPPORT_M = 1'b1
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output fmt_e            fmt,
  output logic            illegal
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm32;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic [5:0]  shift_hi;
  logic        shift_lo_ok;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Shift-immediate funct7 check: on RV64 bit 25 is shamt[5] and is not constrained
  assign shift_hi    = instr[31:26];
  assign shift_lo_ok = (XLEN == 64) || !instr[25];

  // All immediates are formed at 32 bits and then sign-extended to XLEN
  assign imm = XLEN'($signed(imm32));

  // Classify by opcode and flag reserved funct encodings
  always_comb begin
    imm32   = '0;
    fmt     = FMT_R;
    illegal = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        fmt   = FMT_U;
        imm32 = imm_u;
      end
      OPC_JAL: begin
        fmt   = FMT_J;
        imm32 = imm_j;
      end
      OPC_JALR: begin
        fmt     = FMT_I;
        imm32   = imm_i;
        illegal = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        fmt     = FMT_B;
        imm32   = imm_b;
        illegal = (funct3[2:1] == 2'b01);
      end
      OPC_LOAD: begin
        fmt     = FMT_I;
        imm32   = imm_i;
        illegal = (funct3 == 3'b111) ||
                  ((XLEN == 32) && ((funct3 == 3'b011) || (funct3 == 3'b110)));
      end
      OPC_STORE: begin
        fmt     = FMT_S;
        imm32   = imm_s;
        illegal = funct3[2] || ((XLEN == 32) && (funct3 == 3'b011));
      end
      OPC_OP_IMM: begin
        fmt   = FMT_I;
        imm32 = imm_i;
        if (funct3 == 3'b001)
          illegal = !((shift_hi == 6'b000000) && shift_lo_ok);
        else if (funct3 == 3'b101)
          illegal = !(((shift_hi == 6'b000000) || (shift_hi == 6'b010000)) && shift_lo_ok);
      end
      OPC_OP: begin
        fmt     = FMT_R;
        illegal = !((funct7 == 7'b0000000) ||
                    ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101))) ||
                    (SUPPORT_M && (funct7 == 7'b0000001)));
      end
      OPC_MISC_MEM, OPC_SYSTEM: begin
        fmt   = FMT_I;
        imm32 = imm_i;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered decode stage with 2-entry skid buffer and flush
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit SUPPORT_M = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    decoded_t        dec;
  } bundle_t;

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_e;

  state_e          state;
  bundle_t         main_q;
  bundle_t         skid_q;
  bundle_t         incoming;
  logic [XLEN-1:0] dec_imm;
  fmt_e            dec_fmt;
  logic            dec_illegal;
  logic            accept;
  logic            drain;

  imm_gen #(
    .XLEN      (XLEN),
    .SUPPORT_M (SUPPORT_M)
  ) u_imm_gen (
    .instr   (in_instr),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  // Assemble the decoded bundle for the instruction currently offered by fetch
  always_comb begin
    incoming             = '0;
    incoming.pc          = in_pc;
    incoming.imm         = dec_imm;
    incoming.dec.rs1     = in_instr[19:15];
    incoming.dec.rs2     = in_instr[24:20];
    incoming.dec.rd      = in_instr[11:7];
    incoming.dec.opcode  = in_instr[6:0];
    incoming.dec.funct3  = in_instr[14:12];
    incoming.dec.funct7  = in_instr[31:25];
    incoming.dec.fmt     = dec_fmt;
    incoming.dec.illegal = dec_illegal;
  end

  assign accept = in_valid && in_ready;
  assign drain  = out_valid && out_ready;

  // Occupancy FSM: main_q feeds the outputs, skid_q catches the one extra bundle under backpressure
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else if (flush) begin
      state     <= ST_EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            main_q    <= incoming;
            out_valid <= 1'b1;
            state     <= ST_ONE;
          end
        end
        ST_ONE: begin
          case ({accept, drain})
            2'b10: begin
              skid_q   <= incoming;
              in_ready <= 1'b0;
              state    <= ST_FULL;
            end
            2'b01: begin
              out_valid <= 1'b0;
              state     <= ST_EMPTY;
            end
            2'b11: main_q <= incoming;
            default: ;
          endcase
        end
        ST_FULL: begin
          if (drain) begin
            main_q   <= skid_q;
            in_ready <= 1'b1;
            state    <= ST_ONE;
          end
        end
        default: begin
          state     <= ST_EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_pc      = main_q.pc;
  assign out_imm     = main_q.imm;
  assign out_rs1     = main_q.dec.rs1;
  assign out_rs2     = main_q.dec.rs2;
  assign out_rd      = main_q.dec.rd;
  assign out_opcode  = main_q.dec.opcode;
  assign out_funct3  = main_q.dec.funct3;
  assign out_funct7  = main_q.dec.funct7;
  assign out_fmt     = main_q.dec.fmt;
  assign out_illegal = main_q.dec.illegal;

endmodule
